om_range_sequencer: RTL
=======================

# om_range_sequencer

Write-side controller for the overflow-range circular buffer (`circular_buffer_om`). It accepts completed address ranges from two independent trackers: the heap store-overflow tracker (requester 0) and the dataleak load tracker (requester 1). The two are arbitrated round-robin, filtered for invalid and duplicate ranges, and queued in a small FIFO. The block then issues at most one buffer write per cycle and sequences buffer clears, blocking writes while a clear is in progress.

## Interface

Parameters:

- `ADDR_W`, 32, width of range start/end addresses.
- `FIFO_DEPTH`, 4, queued ranges awaiting write; power of two, ≥2.
- `CLEAR_CYCLES`, 8, cycles `buf_rst_o` is held during a clear; ≥1.

Ports:

- `clk_i` in 1: clock; one clock domain.
- `rst_ni` in 1: reset, synchronous, active-low.
- `req0_valid_i` in 1: heap tracker offers a range.
- `req0_ready_o` out 1: range 0 accepted this cycle when valid&ready.
- `req0_start_i`, `req0_end_i` in `ADDR_W`: range 0 bounds, inclusive.
- `req1_valid_i`, `req1_ready_o`, `req1_start_i`, `req1_end_i`: same for the dataleak tracker.
- `clear_req_i` in 1: one-cycle request to flush the circular buffer.
- `buf_en_write_o` out 1: write strobe to the circular buffer, one cycle per range.
- `buf_addr_first_o`, `buf_addr_last_o` out `ADDR_W`: range written when strobe is high.
- `buf_rst_o` out 1: clear strobe to the circular buffer.
- `busy_o` out 1: clear in progress, FIFO non-empty, or write strobe high.
- `fifo_count_o` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `drop_count_o` out 16: saturating count of discarded ranges.

## Operation

- States: RUN, CLEAR. Reset state is RUN.
- **Arbitration (RUN only):**
  - Grant to one requester per cycle, and only if the FIFO is not full and `clear_req_i`=0.
  - If both requesters are valid, grant the one not granted last. The last-grant pointer resets to 1, so requester 0 wins first.
  - A single valid requester is granted regardless of the pointer.
  - The pointer updates only on an actual handshake.
  - `reqN_ready_o` is combinational: it is high in the cycle requester N is granted and low otherwise, including during reset, in CLEAR, and when the FIFO is full.
- **Filter, applied to the granted range at the handshake:**
  - If start > end (unsigned), discard.
  - If start/end equal the last-written register, discard.
  - Otherwise push to the FIFO.
  - Every discard increments `drop_count_o`, saturating at 0xFFFF.
  - A discarded range still consumes its handshake and advances the pointer.
- **Last-written register:**
  - Holds the most recent range pushed to the FIFO, not the most recent one written out.
  - Cleared to an invalid marker (valid bit 0) by reset and on entry to CLEAR.
- **Drain (RUN):**
  - When the FIFO is non-empty and `clear_req_i`=0, pop the head.
  - In the next cycle drive `buf_en_write_o`=1 with the popped start/end.
  - Outputs are registered.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - A push is never permitted into a full FIFO, even if a pop occurs that cycle.
- **Clear:**
  - `clear_req_i`=1 in RUN moves the block to CLEAR at the next edge and flushes the FIFO (count 0).
  - In that request cycle, no grant and no pop are made.
  - `buf_rst_o`=1 for exactly `CLEAR_CYCLES` consecutive cycles, starting the cycle after the request. The block returns to RUN after the last one.
  - `clear_req_i` is ignored while in CLEAR.
  - A write strobe already registered in the request cycle still completes; a clear never truncates a write.
- `drop_count_o` is not cleared by CLEAR; only reset clears it.

## Timing

- Reset values:
  - `buf_en_write_o`, `buf_rst_o`, `busy_o` = 0.
  - Addresses = 0.
  - `fifo_count_o` = 0, `drop_count_o` = 0.
  - Readies = 0 while `rst_ni`=0.
- Reset asserted mid-write or mid-clear: all state returns to reset values at the next edge; no partial strobe continues.
- Latency, with an empty FIFO: handshake in cycle t → push at edge t → pop in cycle t+1 → `buf_en_write_o` high in cycle t+2.
- Throughput: one accept and one write per cycle in steady state.
- Clear: request in cycle t → `buf_rst_o` high in cycles t+1 … t+`CLEAR_CYCLES` → readies may assert again in cycle t+`CLEAR_CYCLES`+1.

## Test plan

- Single range, requester 0, start=0x1000, end=0x100F, handshake in cycle 5 → `buf_en_write_o`=1 in cycle 7 only, first=0x1000, last=0x100F; `drop_count_o`=0.
- Both requesters valid every cycle with distinct ranges → grants in order 0,1,0,1; writes appear in the same order, 2 cycles after each handshake.
- Requester 0 streams 6 distinct ranges while `buf_en_write_o` is observed, with the FIFO at 4 → readies never high while `fifo_count_o`=4 without a same-cycle pop making space next cycle; all 6 ranges are written in order with none lost.
- Ranges (0x200,0x1FF), then (0x300,0x30F) twice → one write (0x300,0x30F); `drop_count_o`=2.
- 3 ranges queued, `clear_req_i` pulsed in cycle 10 → `fifo_count_o`=0 in cycle 11; `buf_rst_o` high in cycles 11–18 (`CLEAR_CYCLES`=8); no writes in 11–18; readies low through cycle 18; a new range written after it is accepted even if equal to a pre-clear range.
- Reset deasserted in the middle of CLEAR, then reasserted → `buf_rst_o`=0 at the next edge, state RUN, counters 0.

Source files
------------

// File: rtl/om_range_sequencer_if.sv
// Handshake and buffer-side bundle for om_range_sequencer.
// master: range trackers + clear source (tb). slave: the sequencer.
//   req0/req1 : valid/ready handshake with inclusive start/end bounds
//   clear_req : one-cycle flush request
//   buf_*     : circular buffer write/clear strobes and range
//   busy/fifo_count/drop_count : status
interface om_range_sequencer_if #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [ADDR_W-1:0] req0_start_i;
    logic [ADDR_W-1:0] req0_end_i;
    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [ADDR_W-1:0] req1_start_i;
    logic [ADDR_W-1:0] req1_end_i;
    logic              clear_req_i;
    logic              buf_en_write_o;
    logic [ADDR_W-1:0] buf_addr_first_o;
    logic [ADDR_W-1:0] buf_addr_last_o;
    logic              buf_rst_o;
    logic              busy_o;
    logic [CW-1:0]     fifo_count_o;
    logic [15:0]       drop_count_o;

    modport master (
        output req0_valid_i, req0_start_i, req0_end_i,
        output req1_valid_i, req1_start_i, req1_end_i,
        output clear_req_i,
        input  req0_ready_o, req1_ready_o,
        input  buf_en_write_o, buf_addr_first_o, buf_addr_last_o,
        input  buf_rst_o, busy_o, fifo_count_o, drop_count_o
    );

    modport slave (
        input  req0_valid_i, req0_start_i, req0_end_i,
        input  req1_valid_i, req1_start_i, req1_end_i,
        input  clear_req_i,
        output req0_ready_o, req1_ready_o,
        output buf_en_write_o, buf_addr_first_o, buf_addr_last_o,
        output buf_rst_o, busy_o, fifo_count_o, drop_count_o
    );
endinterface

// File: rtl/om_range_sequencer.sv
// Write-side controller for the overflow-range circular buffer.
// Ports: clk_i, rst_ni (sync, active-low), bus (slave modport):
//   two round-robin range requesters, filtered (start>end, repeat of
//   last pushed) into a FIFO, drained one buffer write per cycle;
//   clear_req_i flushes the FIFO and holds buf_rst_o for CLEAR_CYCLES.
module om_range_sequencer #(
    parameter int ADDR_W       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLEAR_CYCLES = 8
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    om_range_sequencer_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLEAR_CYCLES + 1);

    typedef enum logic {RUN, CLEAR} state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [ADDR_W-1:0] mem_s_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_e_q [FIFO_DEPTH];
    logic [PW-1:0]     wp_q, rp_q;
    logic [CW-1:0]     cnt_q;
    logic              last_q;
    logic              lw_v_q;
    logic [ADDR_W-1:0] lw_s_q, lw_e_q;
    logic              wen_q;
    logic [ADDR_W-1:0] af_q, al_q;
    logic [15:0]       drop_q;

    logic              run, enter_clr, full, can_grant;
    logic              g0, g1, hs, bad, dup, push, drop, pop;
    logic [ADDR_W-1:0] s, e;

    assign run       = (state_q == RUN);
    assign enter_clr = run && bus.clear_req_i;
    assign full      = (cnt_q == CW'(FIFO_DEPTH));
    // Readies stay low in reset so no handshake lands on a reset edge.
    assign can_grant = rst_ni && run && !bus.clear_req_i && !full;

    // last_q = 1 means requester 1 was granted last, so 0 wins a tie.
    assign g0 = can_grant && bus.req0_valid_i
                && (!bus.req1_valid_i || last_q);
    assign g1 = can_grant && bus.req1_valid_i
                && (!bus.req0_valid_i || !last_q);
    assign hs = g0 || g1;

    assign s    = g1 ? bus.req1_start_i : bus.req0_start_i;
    assign e    = g1 ? bus.req1_end_i   : bus.req0_end_i;
    assign bad  = (s > e);
    assign dup  = lw_v_q && (s == lw_s_q) && (e == lw_e_q);
    assign push = hs && !bad && !dup;
    assign drop = hs && (bad || dup);
    assign pop  = run && !bus.clear_req_i && (cnt_q != '0);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            RUN: begin
                if (bus.clear_req_i) begin
                    state_d = CLEAR;
                    tmr_d   = TW'(CLEAR_CYCLES - 1);
                end
            end
            CLEAR: begin
                if (tmr_q == '0) state_d = RUN;
                else             tmr_d   = tmr_q - TW'(1);
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RUN;
            tmr_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            lw_v_q  <= 1'b0;
            lw_s_q  <= '0;
            lw_e_q  <= '0;
            wen_q   <= 1'b0;
            af_q    <= '0;
            al_q    <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            if (hs) last_q <= g1;
            if (enter_clr) begin
                wp_q   <= '0;
                rp_q   <= '0;
                cnt_q  <= '0;
                lw_v_q <= 1'b0;
            end else begin
                if (push) begin
                    wp_q   <= wp_q + PW'(1);
                    lw_v_q <= 1'b1;
                    lw_s_q <= s;
                    lw_e_q <= e;
                end
                if (pop) rp_q <= rp_q + PW'(1);
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
            wen_q <= pop;
            if (pop) begin
                af_q <= mem_s_q[rp_q];
                al_q <= mem_e_q[rp_q];
            end
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_s_q[wp_q] <= s;
            mem_e_q[wp_q] <= e;
        end
    end

    assign bus.req0_ready_o     = g0;
    assign bus.req1_ready_o     = g1;
    assign bus.buf_en_write_o   = wen_q;
    assign bus.buf_addr_first_o = af_q;
    assign bus.buf_addr_last_o  = al_q;
    assign bus.buf_rst_o        = !run;
    assign bus.busy_o           = !run || (cnt_q != '0) || wen_q;
    assign bus.fifo_count_o     = cnt_q;
    assign bus.drop_count_o     = drop_q;
endmodule
